// File: rtl/coin_acceptor.sv
// Coin acceptor front-end: it synchronizes and debounces the nickel/dime sensors, queues coin events,
// and emits one-cycle coin codes separated by an idle gap. Defining COIN_TOTAL_EN adds a running total_value output.
module coin_acceptor #(
    parameter int unsigned DEBOUNCE  = 4,
    parameter int unsigned GAP       = 2,
    parameter int unsigned QDEPTH    = 4,
    parameter int unsigned JAM_LIMIT = 64
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       nickel_raw,
    input  logic       dime_raw,
    output logic [1:0] coin,
    output logic       reject,
    output logic       jam
`ifdef COIN_TOTAL_EN
    ,
    output logic [7:0] total_value
`endif
);

    localparam int unsigned DB_W  = 4;
    localparam int unsigned GAP_W = 3;
    localparam int unsigned PTR_W = $clog2(QDEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned JAM_W = $clog2(JAM_LIMIT + 1);

    localparam logic [1:0] CODE_NONE   = 2'b00;
    localparam logic [1:0] CODE_NICKEL = 2'b01;
    localparam logic [1:0] CODE_DIME   = 2'b10;

    // Bit 0 is nickel and bit 1 is dime throughout the sensor path.
    logic [1:0]       raw;
    logic [1:0]       sync1;
    logic [1:0]       sync2;
    logic [1:0]       level;
    logic [1:0]       level_d;
    logic [DB_W-1:0]  db_cnt  [2];
    logic [JAM_W-1:0] jam_cnt [2];

    logic [1:0]       q_mem [QDEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] q_count;
    logic [GAP_W-1:0] gap_cnt;

    logic [1:0]       rise;
    logic             ev_valid;
    logic [1:0]       ev_code;
    logic             q_full;
    logic             push;
    logic             pop;
    logic             jam_hit;

    logic [PTR_W-1:0] wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_next;
    logic [CNT_W-1:0] q_count_next;
    logic [GAP_W-1:0] gap_next;
    logic [1:0]       coin_next;
    logic             reject_next;
    logic             jam_next;

    assign raw = {dime_raw, nickel_raw};

    // The synchronizer, the debounce counters and the jam-duration counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1   <= '0;
            sync2   <= '0;
            level   <= '0;
            level_d <= '0;
            for (int s = 0; s < 2; s++) begin
                db_cnt[s]  <= '0;
                jam_cnt[s] <= '0;
            end
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            level_d <= level;
            for (int s = 0; s < 2; s++) begin
                if (sync2[s] == level[s]) begin
                    db_cnt[s] <= '0;
                end else if (db_cnt[s] == DB_W'(DEBOUNCE - 1)) begin
                    level[s]  <= ~level[s];
                    db_cnt[s] <= '0;
                end else begin
                    db_cnt[s] <= db_cnt[s] + DB_W'(1);
                end

                if (!level[s]) begin
                    jam_cnt[s] <= '0;
                end else if (jam_cnt[s] != JAM_W'(JAM_LIMIT)) begin
                    jam_cnt[s] <= jam_cnt[s] + JAM_W'(1);
                end
            end
        end
    end

    // Event detection, queue control and output sequencing.
    always_comb begin
        rise         = '0;
        ev_valid     = 1'b0;
        ev_code      = CODE_NONE;
        q_full       = 1'b0;
        push         = 1'b0;
        pop          = 1'b0;
        jam_hit      = 1'b0;
        wr_ptr_next  = wr_ptr;
        rd_ptr_next  = rd_ptr;
        q_count_next = q_count;
        gap_next     = gap_cnt;
        coin_next    = CODE_NONE;
        reject_next  = 1'b0;
        jam_next     = jam;

        rise = level & ~level_d & {2{~jam}};
        if (rise == 2'b01) begin
            ev_valid = 1'b1;
            ev_code  = CODE_NICKEL;
        end else if (rise == 2'b10) begin
            ev_valid = 1'b1;
            ev_code  = CODE_DIME;
        end

        // Full is judged before any same-cycle pop, so a full queue always rejects.
        q_full = (q_count == CNT_W'(QDEPTH));
        push   = ev_valid && !q_full;
        pop    = (q_count != '0) && (gap_cnt == '0);

        reject_next = (&rise) || (ev_valid && q_full);

        if (push) begin
            wr_ptr_next = wr_ptr + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_next = rd_ptr + PTR_W'(1);
            coin_next   = q_mem[rd_ptr];
        end
        case ({push, pop})
            2'b10:   q_count_next = q_count + CNT_W'(1);
            2'b01:   q_count_next = q_count - CNT_W'(1);
            default: q_count_next = q_count;
        endcase

        if (pop) begin
            gap_next = GAP_W'(GAP);
        end else if (gap_cnt != '0) begin
            gap_next = gap_cnt - GAP_W'(1);
        end

        jam_hit  = (level[0] && (jam_cnt[0] == JAM_W'(JAM_LIMIT - 1)))
                || (level[1] && (jam_cnt[1] == JAM_W'(JAM_LIMIT - 1)));
        jam_next = jam || jam_hit;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            q_count <= '0;
            gap_cnt <= '0;
            coin    <= CODE_NONE;
            reject  <= 1'b0;
            jam     <= 1'b0;
        end else begin
            wr_ptr  <= wr_ptr_next;
            rd_ptr  <= rd_ptr_next;
            q_count <= q_count_next;
            gap_cnt <= gap_next;
            coin    <= coin_next;
            reject  <= reject_next;
            jam     <= jam_next;
        end
    end

    // The queue storage has no reset: the occupancy count alone decides validity.
    always_ff @(posedge clock) begin
        if (push) begin
            q_mem[wr_ptr] <= ev_code;
        end
    end

`ifdef COIN_TOTAL_EN
    logic [8:0] total_sum;
    logic [7:0] total_next;

    always_comb begin
        total_sum  = {1'b0, total_value};
        total_next = total_value;
        if (pop) begin
            total_sum  = {1'b0, total_value} + ((q_mem[rd_ptr] == CODE_DIME) ? 9'd10 : 9'd5);
            total_next = total_sum[8] ? 8'hFF : total_sum[7:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            total_value <= '0;
        end else begin
            total_value <= total_next;
        end
    end
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// Bench for coin_acceptor. It drives a default instance and a fast instance (DEBOUNCE=1, GAP=7, QDEPTH=2);
// the fast instance is needed to overflow the queue.
module tb_coin_acceptor;

    localparam int unsigned DEBOUNCE = 4;
    localparam int unsigned GAP      = 2;
    localparam int unsigned F_GAP    = 7;

    logic       clock = 1'b0;
    logic       reset;
    logic       nickel_raw, dime_raw;
    logic       f_nickel_raw, f_dime_raw;
    logic [1:0] coin, f_coin;
    logic       reject, f_reject;
    logic       jam, f_jam;
`ifdef COIN_TOTAL_EN
    logic [7:0] total_value, f_total_value;
`endif

    coin_acceptor #(.DEBOUNCE(4), .GAP(2), .QDEPTH(4), .JAM_LIMIT(64)) u_dut (
        .clock(clock), .reset(reset), .nickel_raw(nickel_raw), .dime_raw(dime_raw),
        .coin(coin), .reject(reject), .jam(jam)
`ifdef COIN_TOTAL_EN
        , .total_value(total_value)
`endif
    );

    coin_acceptor #(.DEBOUNCE(1), .GAP(7), .QDEPTH(2), .JAM_LIMIT(64)) u_fast (
        .clock(clock), .reset(reset), .nickel_raw(f_nickel_raw), .dime_raw(f_dime_raw),
        .coin(f_coin), .reject(f_reject), .jam(f_jam)
`ifdef COIN_TOTAL_EN
        , .total_value(f_total_value)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0] code;
        int         cyc;
    } exp_t;

    exp_t sb_m[$];
    exp_t sb_f[$];
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   cyc    = 0;
    int   rej_m  = 0;
    int   rej_f  = 0;
    int   idle_m = 100;
    int   idle_f = 100;
    bit   mon_en = 1'b0;
    int   rej_base;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Scoreboard monitors: each coin pulse must match the head expectation in code and cycle.
    always @(negedge clock) begin : mon_main
        exp_t e;
        if (mon_en) begin
            if (reject === 1'b1) rej_m++;
            if (coin !== 2'b00) begin
                check("main_coin_expected", 32'(sb_m.size() > 0), 32'd1);
                check("main_gap_idle", 32'(idle_m >= int'(GAP)), 32'd1);
                if (sb_m.size() > 0) begin
                    e = sb_m.pop_front();
                    check("main_code", 32'(coin), 32'(e.code));
                    check("main_cycle", 32'(cyc), 32'(e.cyc));
                end
                idle_m = 0;
            end else begin
                idle_m++;
            end
        end
    end

    always @(negedge clock) begin : mon_fast
        exp_t e;
        if (mon_en) begin
            if (f_reject === 1'b1) rej_f++;
            if (f_coin !== 2'b00) begin
                check("fast_coin_expected", 32'(sb_f.size() > 0), 32'd1);
                check("fast_gap_idle", 32'(idle_f >= int'(F_GAP)), 32'd1);
                if (sb_f.size() > 0) begin
                    e = sb_f.pop_front();
                    check("fast_code", 32'(f_coin), 32'(e.code));
                    check("fast_cycle", 32'(cyc), 32'(e.cyc));
                end
                idle_f = 0;
            end else begin
                idle_f++;
            end
        end
    end

    initial begin
        reset = 1'b1;
        nickel_raw = 1'b0;
        dime_raw = 1'b0;
        f_nickel_raw = 1'b0;
        f_dime_raw = 1'b0;
        tick(2);
        check("reset_coin", 32'(coin), 32'd0);
        check("reset_reject", 32'(reject), 32'd0);
        check("reset_jam", 32'(jam), 32'd0);
        check("reset_fast_coin", 32'(f_coin), 32'd0);
`ifdef COIN_TOTAL_EN
        check("reset_total", 32'(total_value), 32'd0);
`endif
        reset = 1'b0;
        mon_en = 1'b1;
        tick(3);

        // A clean nickel and then a clean dime.
        rej_base = rej_m;
        sb_m.push_back('{2'b01, cyc + int'(DEBOUNCE) + 4});
        nickel_raw = 1'b1;
        tick(10);
        nickel_raw = 1'b0;
        tick(20);
        sb_m.push_back('{2'b10, cyc + int'(DEBOUNCE) + 4});
        dime_raw = 1'b1;
        tick(10);
        dime_raw = 1'b0;
        tick(20);
        check("clean_sb_drained", 32'(sb_m.size()), 32'd0);
        check("clean_no_reject", 32'(rej_m - rej_base), 32'd0);

        // Bounce on the nickel line, then the line holds steady.
        for (int i = 0; i < 6; i++) begin
            nickel_raw = (i % 2 == 0);
            tick(1);
        end
        sb_m.push_back('{2'b01, cyc + int'(DEBOUNCE) + 4});
        nickel_raw = 1'b1;
        tick(10);
        nickel_raw = 1'b0;
        tick(20);
        check("bounce_sb_drained", 32'(sb_m.size()), 32'd0);

        // A short dime glitch.
        rej_base = rej_m;
        dime_raw = 1'b1;
        tick(3);
        dime_raw = 1'b0;
        tick(20);
        check("glitch_no_reject", 32'(rej_m - rej_base), 32'd0);

        // Both sensors rise together.
        rej_base = rej_m;
        nickel_raw = 1'b1;
        dime_raw = 1'b1;
        tick(10);
        nickel_raw = 1'b0;
        dime_raw = 1'b0;
        tick(20);
        check("simul_one_reject", 32'(rej_m - rej_base), 32'd1);
        check("simul_no_coin", 32'(sb_m.size()), 32'd0);

        // Queue overflow on the fast instance: one dime, then three nickels; the third nickel overflows.
        rej_base = rej_f;
        sb_f.push_back('{2'b10, cyc + 5});
        sb_f.push_back('{2'b01, cyc + 13});
        sb_f.push_back('{2'b01, cyc + 21});
        f_dime_raw = 1'b1;
        tick(1);
        f_dime_raw = 1'b0;
        for (int i = 0; i < 6; i++) begin
            f_nickel_raw = (i % 2 == 0);
            tick(1);
        end
        f_nickel_raw = 1'b0;
        tick(30);
        check("queue_overflow_reject", 32'(rej_f - rej_base), 32'd1);
        check("queue_sb_drained", 32'(sb_f.size()), 32'd0);
`ifdef COIN_TOTAL_EN
        check("queue_total", 32'(f_total_value), 32'd20);
`endif

        // A dime held high until the sensor jams.
        rej_base = rej_m;
        sb_m.push_back('{2'b10, cyc + int'(DEBOUNCE) + 4});
        dime_raw = 1'b1;
        tick(69);
        check("jam_not_yet", 32'(jam), 32'd0);
        tick(1);
        check("jam_set", 32'(jam), 32'd1);
        tick(10);
        dime_raw = 1'b0;
        tick(20);
        nickel_raw = 1'b1;
        tick(10);
        nickel_raw = 1'b0;
        tick(20);
        check("jam_sticky", 32'(jam), 32'd1);
        check("jam_no_reject", 32'(rej_m - rej_base), 32'd0);
        check("jam_sb_drained", 32'(sb_m.size()), 32'd0);
`ifdef COIN_TOTAL_EN
        check("total_before_reset", 32'(total_value), 32'd30);
`endif

        reset = 1'b1;
        tick(2);
        check("jam_reset_jam", 32'(jam), 32'd0);
        check("jam_reset_coin", 32'(coin), 32'd0);
`ifdef COIN_TOTAL_EN
        check("jam_reset_total", 32'(total_value), 32'd0);
`endif
        reset = 1'b0;
        tick(3);
        sb_m.push_back('{2'b01, cyc + int'(DEBOUNCE) + 4});
        nickel_raw = 1'b1;
        tick(10);
        nickel_raw = 1'b0;
        tick(20);
        check("after_reset_sb_drained", 32'(sb_m.size()), 32'd0);
        check("after_reset_jam", 32'(jam), 32'd0);
`ifdef COIN_TOTAL_EN
        check("after_reset_total", 32'(total_value), 32'd5);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
